// File: rtl/if_id_buffer_pkg.sv
// ---------------------------------------------------------------------------
// if_id_buffer_pkg
// Shared IF/ID pipeline definitions: instruction width, the NOP bubble word
// and the IF/ID entry payload reused by the decode stage.
// ---------------------------------------------------------------------------
package if_id_buffer_pkg;

  localparam int unsigned INST_W = 32;

  // sll $0,$0,0 -- the architectural NOP presented as a bubble
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

  // One IF/ID entry: fetched instruction and its next-PC
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [INST_W-1:0] pc4;
  } ifid_entry_t;

  localparam int unsigned ENTRY_W = $bits(ifid_entry_t);

  // Bubble value for an empty IF/ID stage
  function automatic ifid_entry_t ifid_bubble();
    ifid_entry_t e;
    e.inst = NOP_INST;
    e.pc4  = '0;
    return e;
  endfunction

endpackage

// File: rtl/if_id_buffer_ifid_store.sv
// ---------------------------------------------------------------------------
// ifid_store
// DEPTH x DW register array: one synchronous write port, one asynchronous
// read port. Contents are not reset; occupancy is tracked by the owner.
// Ports:
//   clk      - write clock
//   i_we     - write enable
//   i_waddr  - write index
//   i_wdata  - write data
//   i_raddr  - read index
//   o_rdata  - read data (combinational from i_raddr)
// ---------------------------------------------------------------------------
module ifid_store
  import if_id_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned DW    = ENTRY_W
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DW-1:0]            i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DW-1:0]            o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/if_id_buffer.sv
// ---------------------------------------------------------------------------
// if_id_buffer
// Decoupling FIFO between fetch and decode. Fetch pushes {inst, pc4} with a
// valid/ready handshake; decode sees the head entry, or a NOP bubble when
// empty. A flush (taken branch/jump) empties the buffer in one cycle.
// Ports:
//   clk, reset         - clock, asynchronous active-high reset
//   flush              - discard all contents (wins over push/pop)
//   f_valid/f_ready    - fetch handshake
//   f_inst, f_pc4      - fetched instruction and next-PC
//   d_valid/d_ready    - decode handshake (d_ready low = decode stall)
//   d_inst, d_pc4      - head entry, or NOP/0 when empty
//   count              - current occupancy
// ---------------------------------------------------------------------------
module if_id_buffer
  import if_id_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = INST_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     f_valid,
  input  logic [WIDTH-1:0]         f_inst,
  input  logic [WIDTH-1:0]         f_pc4,
  output logic                     f_ready,
  output logic                     d_valid,
  output logic [WIDTH-1:0]         d_inst,
  output logic [WIDTH-1:0]         d_pc4,
  input  logic                     d_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned DW    = 2 * WIDTH;

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_push;
  logic             w_pop;
  logic [DW-1:0]    w_wdata;
  logic [DW-1:0]    w_rdata;

  // Handshake qualifiers; flush suppresses both. f_ready only looks at
  // registered count, so a pop never opens a same-cycle push when full.
  assign f_ready = (r_count < CNT_W'(DEPTH));
  assign d_valid = (r_count != '0);
  assign w_push  = f_valid & f_ready & ~flush;
  assign w_pop   = d_valid & d_ready & ~flush;
  assign w_wdata = {f_inst, f_pc4};

  // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^PTR_W
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  ifid_store #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_store (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  // Head mux: stale storage is masked to a bubble when empty
  always_comb begin
    d_inst = WIDTH'(NOP_INST);
    d_pc4  = '0;
    if (d_valid) begin
      d_inst = w_rdata[DW-1:WIDTH];
      d_pc4  = w_rdata[WIDTH-1:0];
    end
  end

  assign count = r_count;

endmodule

// File: tb/tb_if_id_buffer.sv
// ---------------------------------------------------------------------------
// tb_if_id_buffer
// Directed bench for if_id_buffer (DEPTH = 2, WIDTH = 32).
// ---------------------------------------------------------------------------
module tb_if_id_buffer;
  import if_id_buffer_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             reset;
  logic             flush;
  logic             f_valid;
  logic [WIDTH-1:0] f_inst;
  logic [WIDTH-1:0] f_pc4;
  logic             f_ready;
  logic             d_valid;
  logic [WIDTH-1:0] d_inst;
  logic [WIDTH-1:0] d_pc4;
  logic             d_ready;
  logic [CNT_W-1:0] count;

  int passed = 0;
  int total  = 0;

  if_id_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .f_valid (f_valid),
    .f_inst  (f_inst),
    .f_pc4   (f_pc4),
    .f_ready (f_ready),
    .d_valid (d_valid),
    .d_inst  (d_inst),
    .d_pc4   (d_pc4),
    .d_ready (d_ready),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one rising edge; sample 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input ifid_entry_t e);
    f_valid = v;
    f_inst  = e.inst;
    f_pc4   = e.pc4;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, ".count"},   64'(count),   64'd0);
    chk({tag, ".d_valid"}, 64'(d_valid), 64'd0);
    chk({tag, ".d_inst"},  64'(d_inst),  64'h0000_0000);
    chk({tag, ".d_pc4"},   64'(d_pc4),   64'd0);
    chk({tag, ".f_ready"}, 64'(f_ready), 64'd1);
  endtask

  task automatic chk_head(input string tag, input int unsigned cnt, input ifid_entry_t e);
    chk({tag, ".count"},   64'(count),   64'(cnt));
    chk({tag, ".d_valid"}, 64'(d_valid), 64'd1);
    chk({tag, ".d_inst"},  64'(d_inst),  64'(e.inst));
    chk({tag, ".d_pc4"},   64'(d_pc4),   64'(e.pc4));
  endtask

  ifid_entry_t e;

  initial begin
    reset   = 1'b1;
    flush   = 1'b0;
    f_valid = 1'b0;
    f_inst  = '0;
    f_pc4   = '0;
    d_ready = 1'b0;

    // Reset is asynchronous: outputs valid before any clock edge
    #3;
    chk_empty("reset_async");
    #9;
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 3; i++) begin
      step();
      chk_empty($sformatf("idle%0d", i));
    end

    // Single pass
    e.inst = 32'h2008_000A; e.pc4 = 32'h0040_0004;
    offer(1'b1, e);
    d_ready = 1'b1;
    step();
    chk_head("single", 1, e);
    offer(1'b0, e);
    step();
    chk_empty("single_drain");

    // Fill and stall
    d_ready = 1'b0;
    e.inst = 32'h1111_1111; e.pc4 = 32'h0000_0104;
    offer(1'b1, e);
    step();
    chk_head("fill1", 1, e);
    e.inst = 32'h2222_2222; e.pc4 = 32'h0000_0108;
    offer(1'b1, e);
    step();
    e.inst = 32'h1111_1111; e.pc4 = 32'h0000_0104;
    chk_head("fill2", 2, e);
    chk("fill2.f_ready", 64'(f_ready), 64'd0);
    e.inst = 32'h3333_3333; e.pc4 = 32'h0000_010C;
    offer(1'b1, e);
    step();
    e.inst = 32'h1111_1111; e.pc4 = 32'h0000_0104;
    chk_head("held", 2, e);
    chk("held.f_ready", 64'(f_ready), 64'd0);
    // Pop while full: third offer still not accepted this edge
    d_ready = 1'b1;
    step();
    e.inst = 32'h2222_2222; e.pc4 = 32'h0000_0108;
    chk_head("pop1", 1, e);
    chk("pop1.f_ready", 64'(f_ready), 64'd1);
    step();
    e.inst = 32'h3333_3333; e.pc4 = 32'h0000_010C;
    chk_head("pop2", 1, e);
    f_valid = 1'b0;
    step();
    chk_empty("pop3");

    // Steady state at count = 1 with pointer wrap
    d_ready = 1'b0;
    e.inst = 32'hA000_0004; e.pc4 = 32'h0000_0004;
    offer(1'b1, e);
    step();
    chk_head("wrap0", 1, e);
    d_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      e.pc4  = 32'((i + 1) * 4);
      e.inst = 32'hA000_0000 | e.pc4;
      offer(1'b1, e);
      step();
      chk_head($sformatf("wrap%0d", i), 1, e);
    end
    f_valid = 1'b0;
    step();
    chk_empty("wrap_drain");

    // Flush while full, with a concurrent push and pop
    d_ready = 1'b0;
    e.inst = 32'h5151_5151; e.pc4 = 32'h0000_0204;
    offer(1'b1, e);
    step();
    e.inst = 32'h5252_5252; e.pc4 = 32'h0000_0208;
    offer(1'b1, e);
    step();
    chk("prefl.count", 64'(count), 64'd2);
    flush   = 1'b1;
    d_ready = 1'b1;
    e.inst = 32'hDEAD_BEEF; e.pc4 = 32'h0000_020C;
    offer(1'b1, e);
    step();
    chk_empty("flush");
    flush   = 1'b0;
    f_valid = 1'b0;
    step();
    chk_empty("postfl");
    // Push right after flush restarts from pointer 0
    d_ready = 1'b0;
    e.inst = 32'h6060_6060; e.pc4 = 32'h0000_0304;
    offer(1'b1, e);
    step();
    chk_head("postfl_push", 1, e);

    // Asynchronous reset between edges with count = 1
    f_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk_empty("rst_mid");
    #1;
    reset = 1'b0;
    step();
    chk_empty("rst_after");
    e.inst = 32'h7070_7070; e.pc4 = 32'h0000_0404;
    offer(1'b1, e);
    step();
    chk_head("rst_resume", 1, e);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/if_id_buffer.md
# if_id_buffer

Decoupling buffer between the instruction-fetch stage and the decode stage of the 5-stage MIPS32 pipeline. It accepts fetched instruction/next-PC pairs from fetch with a valid/ready handshake and presents them in order to decode. When empty it presents a NOP bubble. A taken branch flushes it in one cycle. It replaces a bare IF/ID register, so fetch can keep running while decode stalls, for up to DEPTH entries.

## Interface
- DEPTH, 2, number of entries; power of two, ≥ 2.
- WIDTH, 32, instruction and address width.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- flush  in  1  taken branch or jump; discards all contents.
- f_valid  in  1  fetch offers an entry this cycle.
- f_inst  in  WIDTH  fetched instruction word.
- f_pc4  in  WIDTH  address of the instruction + 4 (fetch adder output).
- f_ready  out  1  buffer can accept an entry this cycle.
- d_valid  out  1  head entry is valid for decode.
- d_inst  out  WIDTH  head instruction, or NOP when empty.
- d_pc4  out  WIDTH  head next-PC, or 0 when empty.
- d_ready  in  1  decode consumes the head this cycle; deasserted on a stall.
- count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Push: when f_valid & f_ready, {f_inst, f_pc4} is written at the write pointer, and the write pointer increments modulo DEPTH.
- Pop: when d_valid & d_ready, the read pointer increments modulo DEPTH.
- count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop, or when neither occurs.
- f_ready = (count < DEPTH). It depends only on registered state and has no combinational path from d_ready. When full, a same-cycle pop does not enable a push.
- d_valid = (count != 0). d_inst and d_pc4 are driven combinationally from the entry at the read pointer.
- Empty: d_valid = 0, d_inst = 32'h0000_0000 (NOP, sll $0,$0,0), d_pc4 = 0. There is no bypass: an entry pushed into an empty buffer is visible on the next cycle.
- Flush has priority over push and pop. On a flush cycle:
  - Any push or pop is ignored.
  - Next state: count = 0, both pointers = 0.
  - Storage contents are don't-care.
- Handshake rules:
  - Fetch holds f_inst and f_pc4 stable while f_valid & !f_ready.
  - The buffer never drops an accepted entry except on flush or reset.
- Wrap-around: both pointers wrap from DEPTH−1 to 0. Full and empty are distinguished by count, not by pointer equality.
- Reset mid-operation: all entries are lost, outputs take their reset values immediately, and operation resumes on the first edge after deassertion.
- Reset values:
  - count = 0, d_valid = 0, d_inst = NOP, d_pc4 = 0.
  - f_ready = 1, both pointers = 0.

## Timing
- Latency from push to head visibility is 1 cycle when empty. Otherwise it is (entries ahead) cycles of pop.
- Throughput is 1 push and 1 pop per cycle in steady state (0 < count < DEPTH).
- Flush asserted in cycle N: d_valid = 0 from cycle N+1. A push offered in N+1 is accepted (f_ready = 1).
- All outputs except d_inst/d_pc4 (read mux) are direct register outputs or simple compares of count.
- Data storage needs no reset; pointers and count reset asynchronously.

## Structure
- The shared pipeline package holds:
  - NOP_INST = 32'h0000_0000
  - INST_W = 32
  - An IF/ID entry typedef {inst, pc4} reused by the decode stage.
- One sub-module: ifid_store, a DEPTH×(2·WIDTH) register array with one synchronous write port and one asynchronous read port.
- Pointer and count logic stay in if_id_buffer.

## Test plan
- Reset then idle:
  - Stimulus: reset high, then low; f_valid = 0.
  - Response: count = 0, d_valid = 0, d_inst = 0x00000000, f_ready = 1 in every cycle.
- Single pass:
  - Stimulus: push {0x2008000A, 0x00400004} with d_ready = 1.
  - Response: d_valid = 1 with exactly those values one cycle later; count returns to 0 the cycle after.
- Fill and stall (DEPTH = 2):
  - Stimulus: d_ready = 0; push 0x11111111, then 0x22222222.
  - Response: count = 2 and f_ready = 0. A third offer, 0x33333333, is held off until a pop; the pop order is 0x11111111, 0x22222222, 0x33333333.
- Simultaneous push/pop at count = 1 with wrap:
  - Stimulus: run 5 consecutive cycles with f_valid = d_ready = 1.
  - Response: count stays 1 and the pointers wrap with no loss or reordering of sequential PCs 0x04, 0x08, 0x0C, …
- Flush while full:
  - Stimulus: count = 2; assert flush together with f_valid = 1 and d_ready = 1.
  - Response: next cycle count = 0, d_valid = 0, and the pushed word does not appear.
- Async reset mid-stream:
  - Stimulus: assert reset between clock edges with count = 1.
  - Response: d_valid = 0 and count = 0 immediately, before the next edge.
